// File: rtl/packet_store_responder_pkg.sv
// Shared constants, state encodings and table entry type for the packet store.
package packet_store_responder_pkg;

  localparam int BUS_WIDTH_BITS = 32;
  localparam int NUM_SLOTS      = 16;
  localparam int SLOT_BEATS     = 64;
  localparam int ID_BITS        = 16;

  localparam int PS_SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int PS_IDX_BITS  = $clog2(SLOT_BEATS);
  localparam int PS_BEAT_BITS = PS_IDX_BITS + 1;
  localparam int PS_ADDR_BITS = PS_SLOT_BITS + PS_IDX_BITS;
  localparam int PS_DEPTH     = NUM_SLOTS * SLOT_BEATS;

  // Read FSM encoding (PKT_STORE_STATES), kept as plain constants for legacy users.
  typedef logic [1:0] pkt_store_state_t;
  localparam pkt_store_state_t PS_IDLE    = 2'd0;
  localparam pkt_store_state_t PS_FETCH   = 2'd1;
  localparam pkt_store_state_t PS_STREAM  = 2'd2;
  localparam pkt_store_state_t PS_RELEASE = 2'd3;

  // One length-table entry per slot.
  typedef struct packed {
    logic [PS_BEAT_BITS-1:0] len;
    logic                    occupied;
  } len_entry_t;

  // Slots are laid out back to back, so the word address is slot*SLOT_BEATS + beat.
  function automatic logic [PS_ADDR_BITS-1:0] beat_addr(
    input logic [PS_SLOT_BITS-1:0] slot,
    input logic [PS_IDX_BITS-1:0]  idx
  );
    return {slot, idx};
  endfunction

endpackage

// File: rtl/packet_store_responder_if.sv
// Write-side and read-side handshake bundle of the packet store.
interface packet_store_responder_if;
  import packet_store_responder_pkg::*;

  logic                      wr_valid_in;
  logic [BUS_WIDTH_BITS-1:0] wr_data_in;
  logic                      wr_last_in;
  logic                      wr_ready_out;
  logic                      wr_done_out;
  logic [ID_BITS-1:0]        wr_slot_id_out;
  logic                      wr_overflow_out;
  logic                      packet_read_req_in;
  logic [ID_BITS-1:0]        packet_read_id_in;
  logic                      read_gnt_out;
  logic                      read_err_out;
  logic                      start_of_packet_out;
  logic                      end_of_packet_out;
  logic                      packet_valid_out;
  logic [BUS_WIDTH_BITS-1:0] packet_bus_out;

  modport slave (
    input  wr_valid_in, wr_data_in, wr_last_in, packet_read_req_in, packet_read_id_in,
    output wr_ready_out, wr_done_out, wr_slot_id_out, wr_overflow_out,
           read_gnt_out, read_err_out, start_of_packet_out, end_of_packet_out,
           packet_valid_out, packet_bus_out
  );

  modport master (
    output wr_valid_in, wr_data_in, wr_last_in, packet_read_req_in, packet_read_id_in,
    input  wr_ready_out, wr_done_out, wr_slot_id_out, wr_overflow_out,
           read_gnt_out, read_err_out, start_of_packet_out, end_of_packet_out,
           packet_valid_out, packet_bus_out
  );

endinterface

// File: rtl/packet_store_responder_ram.sv
// Simple dual-port beat store: one write port, one registered read port.
// The read register returns zero when no read is issued, so it can drive the
// packet bus directly and the bus stays at zero between beats.
module pkt_store_ram
  import packet_store_responder_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [PS_ADDR_BITS-1:0]   waddr,
  input  logic [BUS_WIDTH_BITS-1:0] wdata,
  input  logic                      re,
  input  logic [PS_ADDR_BITS-1:0]   raddr,
  output logic [BUS_WIDTH_BITS-1:0] rdata
);

  logic [BUS_WIDTH_BITS-1:0] mem_r [PS_DEPTH];

  // Array write; the storage itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // One-cycle read latency; idle cycles load zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/packet_store_responder.sv
// Slot-based packet store: packets are written into the lowest free slot and
// replayed as a contiguous beat stream on request, after which the slot is freed.
module packet_store_responder
  import packet_store_responder_pkg::*;
(
  input  logic               CLK,
  input  logic               reset_n,
  packet_store_responder_if.slave bus
);

  len_entry_t               table_r [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]     occ_s;
  logic [NUM_SLOTS-1:0]     occ_next_s;
  logic [PS_SLOT_BITS-1:0]  free_idx_s;
  logic                     any_free_s;

  logic                     wr_busy_r;
  logic [PS_SLOT_BITS-1:0]  wr_slot_r;
  logic [PS_BEAT_BITS-1:0]  wr_cnt_r;
  logic                     wr_ready_r;
  logic                     wr_done_r;
  logic                     wr_overflow_r;
  logic [ID_BITS-1:0]       wr_slot_id_r;
  logic                     wr_accept_s, wr_store_s, wr_commit_s, wr_over_s;
  logic                     wr_busy_next_s, wr_ready_next_s;
  logic [PS_SLOT_BITS-1:0]  wr_slot_s;
  logic [PS_BEAT_BITS-1:0]  wr_cnt_s, wr_len_s;

  pkt_store_state_t         state_r;
  logic [PS_SLOT_BITS-1:0]  rd_slot_r;
  logic [PS_BEAT_BITS-1:0]  rd_len_r;
  logic [PS_BEAT_BITS-1:0]  rd_idx_r;
  logic                     gnt_r, err_r, sop_r, eop_r, valid_r;
  logic                     req_ok_s, release_s, ram_re_s;
  logic [PS_BEAT_BITS-1:0]  ram_ridx_s;
  logic [BUS_WIDTH_BITS-1:0] ram_q_s;

  // Occupancy bitmap gathered from the length table.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occ_s[i] = table_r[i].occupied;
    end
  end

  // Lowest-index free slot (priority encoder on the pre-release bitmap).
  always_comb begin
    free_idx_s = '0;
    any_free_s = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      free_idx_s = occ_s[i] ? free_idx_s : PS_SLOT_BITS'(i);
      any_free_s = any_free_s | ~occ_s[i];
    end
  end

  // Write-side decode: allocation on the first beat, saturation, commit.
  always_comb begin
    wr_accept_s    = bus.wr_valid_in & wr_ready_r;
    wr_slot_s      = wr_busy_r ? wr_slot_r : free_idx_s;
    wr_cnt_s       = wr_busy_r ? wr_cnt_r : '0;
    wr_store_s     = wr_accept_s & (wr_cnt_s < PS_BEAT_BITS'(SLOT_BEATS));
    wr_commit_s    = wr_accept_s & bus.wr_last_in;
    wr_over_s      = wr_commit_s & (wr_cnt_s == PS_BEAT_BITS'(SLOT_BEATS));
    wr_len_s       = wr_over_s ? PS_BEAT_BITS'(SLOT_BEATS) : (wr_cnt_s + PS_BEAT_BITS'(1));
    wr_busy_next_s = wr_commit_s ? 1'b0 : (wr_accept_s ? 1'b1 : wr_busy_r);
    release_s      = (state_r == PS_RELEASE);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occ_next_s[i] = (occ_s[i] | (wr_commit_s & (wr_slot_s == PS_SLOT_BITS'(i))))
                      & ~(release_s & (rd_slot_r == PS_SLOT_BITS'(i)));
    end
    wr_ready_next_s = (|(~occ_next_s)) | wr_busy_next_s;
  end

  // Read-side decode: request check and RAM read address per state.
  always_comb begin
    req_ok_s = (bus.packet_read_id_in < ID_BITS'(NUM_SLOTS))
               & occ_s[bus.packet_read_id_in[PS_SLOT_BITS-1:0]];
    case (state_r)
      PS_FETCH: begin
        ram_re_s   = 1'b1;
        ram_ridx_s = '0;
      end
      PS_STREAM: begin
        ram_re_s   = (rd_idx_r < rd_len_r);
        ram_ridx_s = rd_idx_r;
      end
      default: begin
        ram_re_s   = 1'b0;
        ram_ridx_s = '0;
      end
    endcase
  end

  // Write-side state and registered write status outputs.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_busy_r     <= 1'b0;
      wr_slot_r     <= '0;
      wr_cnt_r      <= '0;
      wr_ready_r    <= 1'b0;
      wr_done_r     <= 1'b0;
      wr_overflow_r <= 1'b0;
      wr_slot_id_r  <= '0;
    end else begin
      wr_busy_r     <= wr_busy_next_s;
      wr_ready_r    <= wr_ready_next_s;
      wr_done_r     <= wr_commit_s;
      wr_overflow_r <= wr_over_s;
      wr_slot_id_r  <= wr_commit_s ? ID_BITS'(wr_slot_s) : '0;
      if (wr_accept_s) begin
        wr_slot_r <= wr_slot_s;
        wr_cnt_r  <= wr_store_s ? (wr_cnt_s + PS_BEAT_BITS'(1)) : wr_cnt_s;
      end
    end
  end

  // Length table: filled on commit, occupancy dropped on release.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        table_r[i] <= '0;
      end
    end else begin
      if (wr_commit_s) begin
        table_r[wr_slot_s].len      <= wr_len_s;
        table_r[wr_slot_s].occupied <= 1'b1;
      end
      if (release_s) begin
        table_r[rd_slot_r].occupied <= 1'b0;
      end
    end
  end

  // Read FSM: grant/reject, fetch beat 0, stream, release the slot.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= PS_IDLE;
      rd_slot_r <= '0;
      rd_len_r  <= '0;
      rd_idx_r  <= '0;
      gnt_r     <= 1'b0;
      err_r     <= 1'b0;
      sop_r     <= 1'b0;
      eop_r     <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      gnt_r <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        PS_IDLE: begin
          if (bus.packet_read_req_in) begin
            if (req_ok_s) begin
              gnt_r     <= 1'b1;
              rd_slot_r <= bus.packet_read_id_in[PS_SLOT_BITS-1:0];
              rd_len_r  <= table_r[bus.packet_read_id_in[PS_SLOT_BITS-1:0]].len;
              state_r   <= PS_FETCH;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        PS_FETCH: begin
          valid_r  <= 1'b1;
          sop_r    <= 1'b1;
          eop_r    <= (rd_len_r == PS_BEAT_BITS'(1));
          rd_idx_r <= PS_BEAT_BITS'(1);
          state_r  <= PS_STREAM;
        end
        PS_STREAM: begin
          sop_r <= 1'b0;
          if (rd_idx_r < rd_len_r) begin
            valid_r  <= 1'b1;
            eop_r    <= (rd_idx_r == (rd_len_r - PS_BEAT_BITS'(1)));
            rd_idx_r <= rd_idx_r + PS_BEAT_BITS'(1);
          end else begin
            valid_r <= 1'b0;
            eop_r   <= 1'b0;
            state_r <= PS_RELEASE;
          end
        end
        PS_RELEASE: begin
          state_r <= PS_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          sop_r   <= 1'b0;
          eop_r   <= 1'b0;
          state_r <= PS_IDLE;
        end
      endcase
    end
  end

  pkt_store_ram u_ram (
    .clk   (CLK),
    .rst_n (reset_n),
    .we    (wr_store_s),
    .waddr (beat_addr(wr_slot_s, wr_cnt_s[PS_IDX_BITS-1:0])),
    .wdata (bus.wr_data_in),
    .re    (ram_re_s),
    .raddr (beat_addr(rd_slot_r, ram_ridx_s[PS_IDX_BITS-1:0])),
    .rdata (ram_q_s)
  );

  assign bus.wr_ready_out        = wr_ready_r;
  assign bus.wr_done_out         = wr_done_r;
  assign bus.wr_slot_id_out      = wr_slot_id_r;
  assign bus.wr_overflow_out     = wr_overflow_r;
  assign bus.read_gnt_out        = gnt_r;
  assign bus.read_err_out        = err_r;
  assign bus.start_of_packet_out = sop_r;
  assign bus.end_of_packet_out   = eop_r;
  assign bus.packet_valid_out    = valid_r;
  assign bus.packet_bus_out      = ram_q_s;

endmodule

// File: tb/tb_packet_store_responder.sv
// Scoreboard bench for the packet store: stimulus pushes expected responses,
// a negedge monitor pops and compares whatever the store presents.
module tb_packet_store_responder;
  import packet_store_responder_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  packet_store_responder_if bus();

  packet_store_responder dut (
    .CLK     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } beat_t;

  beat_t       q_beat[$];
  int          q_gnt[$];
  int          q_err[$];
  int          q_done[$];
  int          q_ovf[$];
  logic [31:0] exp_data [NUM_SLOTS][SLOT_BEATS];
  int          exp_len [NUM_SLOTS];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented response must match the head of its queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.read_gnt_out) begin
        chk("gnt_pending", 64'(q_gnt.size() != 0), 64'd1);
        if (q_gnt.size() != 0) chk("gnt_cycle", 64'(cyc), 64'(q_gnt.pop_front()));
      end
      if (bus.read_err_out) begin
        chk("err_pending", 64'(q_err.size() != 0), 64'd1);
        if (q_err.size() != 0) chk("err_cycle", 64'(cyc), 64'(q_err.pop_front()));
      end
      if (bus.wr_done_out) begin
        chk("done_pending", 64'(q_done.size() != 0), 64'd1);
        if (q_done.size() != 0) chk("done_slot", 64'(bus.wr_slot_id_out), 64'(q_done.pop_front()));
      end
      if (bus.wr_overflow_out) begin
        chk("ovf_pending", 64'(q_ovf.size() != 0), 64'd1);
        if (q_ovf.size() != 0) void'(q_ovf.pop_front());
      end
      if (bus.packet_valid_out) begin
        chk("beat_pending", 64'(q_beat.size() != 0), 64'd1);
        if (q_beat.size() != 0) begin
          beat_t b;
          b = q_beat.pop_front();
          chk("beat_data", 64'(bus.packet_bus_out), 64'(b.data));
          chk("beat_sop", 64'(bus.start_of_packet_out), 64'(b.sop));
          chk("beat_eop", 64'(bus.end_of_packet_out), 64'(b.eop));
          chk("beat_cycle", 64'(cyc), 64'(b.cyc));
        end
      end else begin
        chk("idle_bus", 64'({bus.packet_bus_out, bus.start_of_packet_out, bus.end_of_packet_out}), 64'd0);
      end
    end
  end

  task automatic write_pkt(input int n, input logic [31:0] base, input int slot);
    q_done.push_back(slot);
    if (n > SLOT_BEATS) q_ovf.push_back(1);
    exp_len[slot] = (n > SLOT_BEATS) ? SLOT_BEATS : n;
    for (int i = 0; i < n; i++) begin
      if (i < SLOT_BEATS) exp_data[slot][i] = base + 32'(i);
      bus.wr_valid_in = 1'b1;
      bus.wr_data_in  = base + 32'(i);
      bus.wr_last_in  = (i == n - 1);
      step();
    end
    bus.wr_valid_in = 1'b0;
    bus.wr_last_in  = 1'b0;
    bus.wr_data_in  = 32'd0;
    step();
  endtask

  task automatic push_beats(input int slot, input int first_cyc, input int count);
    beat_t b;
    for (int i = 0; i < count; i++) begin
      b.data = exp_data[slot][i];
      b.sop  = (i == 0);
      b.eop  = (i == exp_len[slot] - 1);
      b.cyc  = first_cyc + i;
      q_beat.push_back(b);
    end
  endtask

  task automatic read_pkt(input int id, input bit ok);
    int c0;
    c0 = cyc;
    bus.packet_read_req_in = 1'b1;
    bus.packet_read_id_in  = 16'(id);
    if (ok) begin
      q_gnt.push_back(c0 + 1);
      push_beats(id, c0 + 2, exp_len[id]);
    end else begin
      q_err.push_back(c0 + 1);
    end
    step();
    bus.packet_read_req_in = 1'b0;
    if (ok) begin
      repeat (exp_len[id] + 6) step();
      exp_len[id] = 0;
    end else begin
      repeat (2) step();
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ready"}, 64'(bus.wr_ready_out), 64'd0);
    chk({name, "_misc"}, 64'({bus.wr_done_out, bus.wr_overflow_out, bus.wr_slot_id_out,
                              bus.read_gnt_out, bus.read_err_out}), 64'd0);
    chk({name, "_stream"}, 64'({bus.packet_valid_out, bus.start_of_packet_out,
                                bus.end_of_packet_out, bus.packet_bus_out}), 64'd0);
  endtask

  initial begin
    int c0;
    reset_n                = 1'b0;
    bus.wr_valid_in        = 1'b0;
    bus.wr_data_in         = 32'd0;
    bus.wr_last_in         = 1'b0;
    bus.packet_read_req_in = 1'b0;
    bus.packet_read_id_in  = 16'd0;
    for (int s = 0; s < NUM_SLOTS; s++) exp_len[s] = 0;
    repeat (3) step();
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    step();
    step();
    chk("ready_after_reset", 64'(bus.wr_ready_out), 64'd1);

    // 5-beat packet into slot 0 and replay.
    write_pkt(5, 32'hA0, 0);
    read_pkt(0, 1'b1);

    // Rejections: freed slot, empty slot, out-of-range id.
    read_pkt(0, 1'b0);
    read_pkt(3, 1'b0);
    read_pkt(16, 1'b0);

    // Fill every slot, free slot 7, refill it.
    for (int s = 0; s < NUM_SLOTS; s++) write_pkt(1, 32'h100 + 32'(s), s);
    chk("ready_full", 64'(bus.wr_ready_out), 64'd0);
    read_pkt(7, 1'b1);
    chk("ready_after_release", 64'(bus.wr_ready_out), 64'd1);
    write_pkt(1, 32'h200, 7);
    chk("ready_refull", 64'(bus.wr_ready_out), 64'd0);
    for (int s = 0; s < NUM_SLOTS; s++) read_pkt(s, 1'b1);

    // Oversized packet saturates at SLOT_BEATS.
    write_pkt(70, 32'h1000, 0);
    read_pkt(0, 1'b1);

    // Held request across a stream with a concurrent write.
    write_pkt(2, 32'hB0, 0);
    write_pkt(3, 32'hC0, 1);
    c0 = cyc;
    bus.packet_read_req_in = 1'b1;
    bus.packet_read_id_in  = 16'd0;
    q_gnt.push_back(c0 + 1);
    push_beats(0, c0 + 2, 2);
    q_gnt.push_back(c0 + 6);
    push_beats(1, c0 + 7, 3);
    fork
      begin
        step();
        bus.packet_read_id_in = 16'd1;
        repeat (5) step();
        bus.packet_read_req_in = 1'b0;
        repeat (8) step();
      end
      begin
        write_pkt(1, 32'hD0, 2);
      end
    join
    exp_len[0] = 0;
    exp_len[1] = 0;
    read_pkt(2, 1'b1);

    // Reset in the middle of a stream (beat 3 of 6).
    write_pkt(6, 32'hE0, 0);
    c0 = cyc;
    bus.packet_read_req_in = 1'b1;
    bus.packet_read_id_in  = 16'd0;
    q_gnt.push_back(c0 + 1);
    push_beats(0, c0 + 2, 3);
    step();
    bus.packet_read_req_in = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("midstream_reset");
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("ready_post_reset", 64'(bus.wr_ready_out), 64'd1);
    read_pkt(0, 1'b0);
    read_pkt(9, 1'b0);
    read_pkt(15, 1'b0);
    repeat (4) step();

    chk("beats_left", 64'(q_beat.size()), 64'd0);
    chk("gnts_left", 64'(q_gnt.size()), 64'd0);
    chk("errs_left", 64'(q_err.size()), 64'd0);
    chk("dones_left", 64'(q_done.size()), 64'd0);
    chk("ovfs_left", 64'(q_ovf.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
